memwb_skid_stage: RTL and testbench

Parametrised MEM/WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, so upstream stalls do not have to be combinationally coupled.
- Sits between the MEM stage and register-file writeback.
- Carries the M2R/RegWr control bits, memory data, ALU result and destination register.
- Adds stall, flush, writeback-data select and a gated register-file write strobe, none of which the previous fixed stage register had.

---
 rtl/memwb_pkg.sv | 26 ++
 rtl/memwb_skid_stage_skid_buf.sv | 89 ++++++++
 rtl/memwb_skid_stage.sv | 75 +++++++
 tb/tb_memwb_skid_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB skid stage: FSM states, default payload layout
// and the payload width helper.
package memwb_pkg;

    localparam int unsigned MEMWB_DW = 32;
    localparam int unsigned MEMWB_AW = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic                m2r;
        logic                regwr;
        logic [MEMWB_DW-1:0] memdata;
        logic [MEMWB_DW-1:0] aluout;
        logic [MEMWB_AW-1:0] rd;
    } memwb_payload_t;

    function automatic int unsigned payload_w(input int unsigned dw, input int unsigned aw);
        return 2 + 2 * dw + aw;
    endfunction

endpackage

// File: rtl/memwb_skid_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends on state only.
module skid_buf
    import memwb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    state_t       state, state_next;
    logic [W-1:0] main_q, skid_q, main_next;
    logic         load_main, load_skid;
    logic         push, pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = main_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_next;
            if (load_main) main_q <= main_next;
            if (load_skid) skid_q <= in_data;
        end
    end

    always_comb begin
        state_next = state;
        main_next  = in_data;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    main_next  = skid_q;
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush only drops validity; payload registers keep their contents.
        if (flush) begin
            state_next = EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
        end
    end

    always_comb begin
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with skid buffering, writeback data select and a
// gated register-file write strobe.
module memwb_skid_stage
    import memwb_pkg::*;
#(
    parameter int unsigned DW             = 32,
    parameter int unsigned AW             = 5,
    parameter bit          ZERO_REG_GUARD = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_m2r,
    input  logic          in_regwr,
    input  logic [DW-1:0] in_memdata,
    input  logic [DW-1:0] in_aluout,
    input  logic [AW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_m2r,
    output logic          out_regwr,
    output logic [DW-1:0] out_memdata,
    output logic [DW-1:0] out_aluout,
    output logic [AW-1:0] out_rd,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [1:0]    occupancy
);

    localparam int unsigned PW = payload_w(DW, AW);

    typedef struct packed {
        logic          m2r;
        logic          regwr;
        logic [DW-1:0] memdata;
        logic [DW-1:0] aluout;
        logic [AW-1:0] rd;
    } payload_t;

    payload_t in_payload, out_payload;
    logic     rd_ok;

    assign in_payload = '{m2r: in_m2r, regwr: in_regwr, memdata: in_memdata,
                          aluout: in_aluout, rd: in_rd};

    skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .occupancy (occupancy)
    );

    assign out_m2r     = out_payload.m2r;
    assign out_regwr   = out_payload.regwr;
    assign out_memdata = out_payload.memdata;
    assign out_aluout  = out_payload.aluout;
    assign out_rd      = out_payload.rd;

    assign rd_ok   = !ZERO_REG_GUARD || (out_payload.rd != '0);
    assign wb_we   = out_valid & out_ready & out_payload.regwr & rd_ok;
    assign wb_addr = out_payload.rd;
    assign wb_data = out_payload.m2r ? out_payload.memdata : out_payload.aluout;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed self-checking bench for memwb_skid_stage; a second instance with
// the register-0 guard disabled shares all inputs.
module tb_memwb_skid_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_m2r, in_regwr;
    logic [DW-1:0] in_memdata, in_aluout;
    logic [AW-1:0] in_rd;

    logic          in_ready, out_valid, out_m2r, out_regwr, wb_we;
    logic [DW-1:0] out_memdata, out_aluout, wb_data;
    logic [AW-1:0] out_rd, wb_addr;
    logic [1:0]    occupancy;

    logic          z_in_ready, z_out_valid, z_out_m2r, z_out_regwr, z_wb_we;
    logic [DW-1:0] z_out_memdata, z_out_aluout, z_wb_data;
    logic [AW-1:0] z_out_rd, z_wb_addr;
    logic [1:0]    z_occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memwb_skid_stage #(.DW(DW), .AW(AW), .ZERO_REG_GUARD(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_m2r(in_m2r), .in_regwr(in_regwr), .in_memdata(in_memdata),
        .in_aluout(in_aluout), .in_rd(in_rd), .out_valid(out_valid),
        .out_ready(out_ready), .out_m2r(out_m2r), .out_regwr(out_regwr),
        .out_memdata(out_memdata), .out_aluout(out_aluout), .out_rd(out_rd),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .occupancy(occupancy)
    );

    memwb_skid_stage #(.DW(DW), .AW(AW), .ZERO_REG_GUARD(1'b0)) dut_nog (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_m2r(in_m2r), .in_regwr(in_regwr), .in_memdata(in_memdata),
        .in_aluout(in_aluout), .in_rd(in_rd), .out_valid(z_out_valid),
        .out_ready(out_ready), .out_m2r(z_out_m2r), .out_regwr(z_out_regwr),
        .out_memdata(z_out_memdata), .out_aluout(z_out_aluout), .out_rd(z_out_rd),
        .wb_we(z_wb_we), .wb_addr(z_wb_addr), .wb_data(z_wb_data), .occupancy(z_occupancy)
    );

    task automatic drive(input logic v, input logic m2r, input logic regwr,
                         input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                         input logic [AW-1:0] rd);
        in_valid   = v;
        in_m2r     = m2r;
        in_regwr   = regwr;
        in_memdata = mem;
        in_aluout  = alu;
        in_rd      = rd;
    endtask

    // Advance one edge and let registered outputs settle before any check.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b ready=%b occ=%0d want 0 1 0", out_valid, in_ready, occupancy);
        end
        checks++;
        if (out_m2r !== 1'b0 || out_regwr !== 1'b0 || out_memdata !== '0 || out_aluout !== '0 || out_rd !== '0) begin
            errors++;
            $display("FAIL reset_payload: m2r=%b regwr=%b mem=%h alu=%h rd=%0d want all 0",
                     out_m2r, out_regwr, out_memdata, out_aluout, out_rd);
        end
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_wb_we: got %b want 0", wb_we);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd5);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (out_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_addr !== 5'd5 || wb_we !== 1'b1) begin
            errors++;
            $display("FAIL single_wb: valid=%b data=%h addr=%0d we=%b want 1 deadbeef 5 1",
                     out_valid, wb_data, wb_addr, wb_we);
        end
        step();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: occ=%0d valid=%b want 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'hA0, 32'd1, 5'd1);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'hB0, 32'd2, 5'd2);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_aluout !== 32'd1 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL skid_full: occ=%0d ready=%b alu=%0d we=%b want 2 0 1 0",
                     occupancy, in_ready, out_aluout, wb_we);
        end
        step();
        checks++;
        if (out_aluout !== 32'd1 || out_rd !== 5'd1 || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL skid_hold: alu=%0d rd=%0d occ=%0d want 1 1 2", out_aluout, out_rd, occupancy);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (wb_data !== 32'd1 || wb_we !== 1'b1 || wb_addr !== 5'd1) begin
            errors++;
            $display("FAIL skid_popA: data=%0d we=%b addr=%0d want 1 1 1", wb_data, wb_we, wb_addr);
        end
        step();
        checks++;
        if (out_aluout !== 32'd2 || out_memdata !== 32'hB0 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL skid_popB: alu=%0d mem=%h ready=%b occ=%0d want 2 b0 1 1",
                     out_aluout, out_memdata, in_ready, occupancy);
        end
        step();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_drain: occ=%0d valid=%b want 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, '0, DW'(i), 5'd7);
            step();
            checks++;
            if (out_aluout !== DW'(i) || occupancy !== 2'd1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: alu=%0d occ=%0d valid=%b ready=%b want %0d 1 1 1",
                         i, out_aluout, occupancy, out_valid, in_ready, i);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: occ=%0d want 0", occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, '0, 32'h11, 5'd3);
        step();
        drive(1'b1, 1'b0, 1'b1, '0, 32'h22, 5'd4);
        step();
        drive(1'b1, 1'b0, 1'b1, '0, 32'h33, 5'd6);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: occ=%0d valid=%b ready=%b we=%b want 0 0 1 0",
                     occupancy, out_valid, in_ready, wb_we);
        end
        checks++;
        if (out_aluout !== 32'h11) begin
            errors++;
            $display("FAIL flush_payload_kept: alu=%h want 11", out_aluout);
        end
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, '0, 32'h44, 5'd8);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (out_aluout !== 32'h44 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL flush_next: alu=%h occ=%0d want 44 1", out_aluout, occupancy);
        end
        step();
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, '0, 32'd7, 5'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        #1;
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_guard_on: we=%b want 0", wb_we);
        end
        checks++;
        if (z_wb_we !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg_guard_off: we=%b want 1", z_wb_we);
        end
        step();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'd9, 5'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        #1;
        checks++;
        if (wb_we !== 1'b0 || z_wb_we !== 1'b0 || wb_data !== 32'h55) begin
            errors++;
            $display("FAIL no_regwr: we=%b zwe=%b data=%h want 0 0 55", wb_we, z_wb_we, wb_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h99, 32'h77, 5'd9);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_aluout !== '0 || out_memdata !== '0) begin
            errors++;
            $display("FAIL reset_mid: occ=%0d valid=%b ready=%b alu=%h mem=%h want 0 0 1 0 0",
                     occupancy, out_valid, in_ready, out_aluout, out_memdata);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_back_to_back();
        test_flush();
        test_zero_reg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
